// File: rtl/ad9361_axis_capture.sv
// Capture controller behind the AD9361 AXI-stream serializer. It drops a settling
// prefix, forwards a fixed-length burst with tlast, and drains upstream when idle.
module ad9361_axis_capture #(
   parameter int DATA_WIDTH   = 96,
   parameter int LENGTH_WIDTH = 16,
   parameter int SKIP_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [LENGTH_WIDTH-1:0] cfg_length,
   input  logic [SKIP_WIDTH-1:0]   cfg_skip,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tlast
);

   typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [LENGTH_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
   logic [SKIP_WIDTH-1:0]   skip_lat_q, skip_lat_d, skip_cnt_q, skip_cnt_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic                    done_q, done_d, aborted_q, aborted_d, busy_q, busy_d;
   logic                    s_ready, out_fire, last_pending;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d      = state_q;
      len_d        = len_q;
      beat_d       = beat_q;
      skip_lat_d   = skip_lat_q;
      skip_cnt_d   = skip_cnt_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      s_ready      = 1'b0;
      out_fire     = m_valid_q & m_axis_tready;
      last_pending = m_valid_q & m_last_q;

      case (state_q)
         IDLE: begin
            s_ready = 1'b1;
            if (start && !abort) begin
               len_d      = cfg_length;
               skip_lat_d = cfg_skip;
               skip_cnt_d = '0;
               beat_d     = '0;
               state_d    = (cfg_skip != '0) ? SKIP : CAPTURE;
            end
         end
         SKIP: begin
            s_ready = 1'b1;
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (s_axis_tvalid) begin
               // Compare against skip-1 so the counter never has to hold skip itself.
               if (skip_cnt_q == skip_lat_q - SKIP_WIDTH'(1)) state_d = CAPTURE;
               else skip_cnt_d = skip_cnt_q + SKIP_WIDTH'(1);
            end
         end
         CAPTURE: begin
            s_ready = ~abort & ~last_pending & (~m_valid_q | m_axis_tready);
            if (out_fire) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
            end
            if (out_fire && m_last_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (abort) begin
               if (m_valid_q && !m_axis_tready) begin
                  state_d = FLUSH;
               end else begin
                  state_d   = IDLE;
                  aborted_d = 1'b1;
               end
            end else if (s_axis_tvalid && s_ready) begin
               m_valid_d = 1'b1;
               m_data_d  = s_axis_tdata;
               m_last_d  = (beat_q == len_q);
               // Hold the index at the final beat so a full-range length cannot wrap.
               if (beat_q != len_q) beat_d = beat_q + LENGTH_WIDTH'(1);
            end
         end
         FLUSH: begin
            if (out_fire) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               state_d   = IDLE;
               aborted_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         beat_q     <= '0;
         skip_lat_q <= '0;
         skip_cnt_q <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         skip_lat_q <= skip_lat_d;
         skip_cnt_q <= skip_cnt_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         busy_q     <= busy_d;
      end
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign busy          = busy_q;

endmodule
